fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side consumer for the team's synchronous FIFO. Drives the FIFO's `rd_en`, absorbs the FIFO's one-cycle registered read latency, and presents words on a valid/ready output stream. A 2-entry output buffer (head plus skid) sustains one word per cycle with no loss or duplication under arbitrary backpressure. It sits between the FIFO read port and any downstream stream consumer.

## Interface
- `DW`, default 8: data width; matches FIFO `wdata`/`rdata`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rdata` in DW: FIFO registered read data. Valid the cycle after a read is issued, then held.
- `fifo_rd_en` out 1: read request to the FIFO.
- `m_valid` out 1: output word valid.
- `m_data` out DW: output word; head of the buffer.
- `m_ready` in 1: downstream accept.
- `rd_count` out 16: accepted-beat counter. Present only with `FIFO_RD_STATS_EN`.

## Operation
- **Ownership:** the block is the sole driver of FIFO `rd_en`.
- **State:**
  - `count` (0..2): buffered words. Entry 0 = head, drives `m_data`; entry 1 = skid.
  - `inflight` (1 bit): a read was issued last cycle.
- **Pop:** `pop = m_valid & m_ready`. `m_valid = (count != 0)`.
- **Read issue:** `fifo_rd_en = rst_n & ~fifo_empty & ((count + inflight - pop) < 2)`.
  - Combinational path from `m_ready` and `fifo_empty` to `fifo_rd_en` is intended.
  - `fifo_rd_en` never asserts when the FIFO is empty, so every assertion is a real read.
- **inflight update:** `inflight <= fifo_rd_en` each cycle.
- **Arrival:** when `inflight`=1, the word on `fifo_rdata` is captured that cycle. Target entry:
  - head if `count`=0, or if `count`=1 and `pop`;
  - skid if `count`=1 and no pop;
  - head-from-skid shift happens first if `count`=2 and `pop`. The credit rule guarantees arrival never occurs with `count`=2 and no pop.
- **Pop with `count`=2:** skid moves to head in the same edge.
- **Ordering:** strict FIFO order is preserved.
- **Count update:** `count` += arrival − pop. Range 0..2 must never be exceeded; the bench asserts this.
- **Stability:** `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- **Reset (asynchronous, any time, including mid-stream):**
  - `count`=0, `inflight`=0, `m_valid`=0, `m_data`=0, skid=0, `rd_count`=0.
  - `fifo_rd_en` is 0 while `rst_n`=0.
  - Any in-flight word is discarded.

## Timing
- **Read latency:** `fifo_rd_en` high in cycle k → `fifo_rdata` valid in cycle k+1 → `m_valid`=1 with that word in cycle k+2. Total latency 2 cycles.
- **Throughput:** 1 word/cycle sustained with `m_ready`=1 and FIFO non-empty.
- **Backpressure:** with `m_ready`=0 from reset, at most 2 reads are issued. Then `fifo_rd_en`=0 until a pop.
- **Resume:** after backpressure ends, a word is popped the same cycle `m_ready` rises. The refill read issues in that same cycle.
- **Empty boundary:** after the last word leaves the FIFO, `fifo_empty` rises and `fifo_rd_en` drops combinationally. No speculative read occurs.
- **Reset outputs:** `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `rd_count`=0.

## Configuration
- **`FIFO_RD_STATS_EN` defined:**
  - Adds port `rd_count`, a 16-bit count of accepted beats (`pop`).
  - Increments on each pop and wraps 0xFFFF→0x0000.
  - Reset to 0.
- **Undefined:** port and counter are absent. Datapath behaviour is otherwise identical.

## Test plan
- **Reset:** hold `rst_n`=0 with `fifo_empty`=0 → `fifo_rd_en`=0, `m_valid`=0, `m_data`=0x00 throughout. Release → first `fifo_rd_en` in the first cycle after release.
- **Single word:** FIFO holds 0xA5, `m_ready`=1 → `fifo_rd_en` high 1 cycle (k). `m_valid`=1 with `m_data`=0xA5 in cycle k+2 only. No second read.
- **Streaming:** 32 words 0x01..0x20 preloaded, `m_ready`=1 → `fifo_rd_en` high 32 consecutive cycles. `m_valid` high 32 consecutive cycles, data 0x01..0x20 in order.
- **Backpressure:** 10 words 0x10..0x19 preloaded, `m_ready`=0.
  - Exactly 2 reads issued.
  - `m_data`=0x10 stable.
  - Toggling `m_ready` 1-0-1-0 delivers 0x10..0x19 in order, no drop or duplicate.
  - `count` ≤ 2 at all times.
- **Reset mid-stream:** assert `rst_n`=0 in the cycle `inflight`=1 with `count`=2 → outputs return to reset values immediately. After release, the next delivered word is the next unread FIFO entry.
- **Stats (`FIFO_RD_STATS_EN`):**
  - 5 pops → `rd_count`=5.
  - Preset 0xFFFE, then 3 pops → `rd_count`=0x0001.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for the synchronous FIFO.
// Issues fifo_rd_en on a credit basis, absorbs the FIFO's one-cycle read
// latency and presents words on a valid/ready stream through a 2-entry
// buffer (head + skid).
// Optional feature: define FIFO_RD_STATS_EN to add the 16-bit rd_count port
// counting accepted beats.
module fifo_rd_stream #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_rd_en,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]   rd_count
`endif
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    buf_state_t    count;
    logic          inflight;
    logic [DW-1:0] head;
    logic [DW-1:0] skid;
    logic          pop;
    logic [2:0]    occupancy;

    // Stream handshake and read credit: a read may issue only when the word
    // it returns is guaranteed a free buffer slot on arrival.
    always_comb begin
        m_valid    = (count != BUF_EMPTY);
        pop        = m_valid & m_ready;
        occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        fifo_rd_en = rst_n & ~fifo_empty & (occupancy < 3'd2);
    end

    assign m_data = head;

    // Buffer occupancy, arrival capture and head/skid movement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= BUF_EMPTY;
            inflight <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case (count)
                BUF_EMPTY: begin
                    if (inflight) begin
                        head  <= fifo_rdata;
                        count <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (inflight && pop) begin
                        head <= fifo_rdata;
                    end else if (inflight) begin
                        skid  <= fifo_rdata;
                        count <= BUF_TWO;
                    end else if (pop) begin
                        count <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    // Skid shifts into head before the arriving word lands in skid.
                    if (pop) begin
                        head <= skid;
                        if (inflight) begin
                            skid <= fifo_rdata;
                        end else begin
                            count <= BUF_ONE;
                        end
                    end
                end
                default: begin
                    count <= BUF_EMPTY;
                end
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    // Accepted-beat counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule
